capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Capture controller directly downstream of the 4-stage trigger block; consumes its run flag plus the same sampled input stream (sti_valid/sti_data).
- Writes samples into an external circular sample RAM before and after the trigger. Once the programmed post-trigger delay has elapsed, reads the RAM back newest-first and hands each sample to the transmitter over a valid/ready handshake.

Parameters:
DW, 32, sample data width
AW, 11, sample RAM address width (RAM depth 2**AW)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
wrSize  in  1  write size register (one-cycle strobe)
config_data  in  32  [15:0]=read_cnt, [31:16]=delay_cnt
arm  in  1  start capture
run  in  1  trigger hit, from trigger block
sti_valid  in  1  input sample strobe
sti_data  in  DW  input sample
mem_wr  out  1  RAM write strobe
mem_rd  out  1  RAM read strobe
mem_addr  out  AW  RAM address (write or read)
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid exactly 1 cycle after mem_rd
tx_valid  out  1  sample available for transmitter
tx_data  out  DW  sample to transmitter
tx_ready  in  1  transmitter accepts tx_data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of readout

Behaviour:
- Reset: state=IDLE; read_cnt=0; delay_cnt=0; wr_ptr=0; cnt=0; all outputs 0.
- Size register: wrSize loads read_cnt/delay_cnt only in IDLE; ignored in every other state.
- States: IDLE, SAMPLE, DELAY, RD_REQ, RD_WAIT, RD_TX.

IDLE:
- arm=1 -> SAMPLE next cycle.
- run ignored.
- wr_ptr retained, not cleared.

SAMPLE:
- Each cycle with sti_valid=1 writes the sample.
- run=1 -> DELAY with cnt=0; the sample in the run cycle (if valid) is still written.
- arm ignored.

Write path (SAMPLE and DELAY):
- Registered, latency 1: cycle after sti_valid gives mem_wr=1, mem_addr=wr_ptr, mem_wdata=sample.
- wr_ptr increments after each write, wraps 2**AW-1 -> 0.

DELAY:
- Each valid sample is written and cnt increments.
- Transition to RD_REQ on the cycle a valid sample makes cnt+1 == delay_cnt; that sample is written.
- delay_cnt=0 -> RD_REQ next cycle; no post-trigger writes.

Read setup:
- On entering RD_REQ: rd_ptr = wr_ptr-1 (mod 2**AW), the last written address; rd_left = read_cnt.
- read_cnt=0 -> IDLE directly, with the done pulse, and no reads.

RD_REQ:
- mem_rd=1, mem_addr=rd_ptr for one cycle -> RD_WAIT.

RD_WAIT:
- Capture mem_rdata into tx_data; assert tx_valid -> RD_TX.

RD_TX:
- Hold tx_valid and tx_data stable until tx_ready=1.
- On handshake: rd_ptr decrements (wraps 0 -> 2**AW-1) and rd_left decrements.
- rd_left becomes 0 -> IDLE with done=1 for one cycle and tx_valid=0; otherwise -> RD_REQ.
- Sustained throughput: 1 sample per 3 cycles.

Counts and wrap:
- cnt, read_cnt and delay_cnt are 16 bits.
- read_cnt > 2**AW wraps the read pointer and re-reads the oldest data; this is legal, not an error.

Other rules:
- mem_wr and mem_rd are never high in the same cycle.
- Transmission is only from RD_TX.
- busy is combinational from state.
- Async reset mid-operation (any state) aborts immediately; no done pulse; outputs go to reset values.

Optional Feature:
- Macro: CAPTURE_CTRL_ABORT_EN.
- When defined:
  - Extra input port abort (1 bit).
  - abort=1 in any non-IDLE state -> IDLE next cycle; tx_valid drops; a pending registered write is still completed; no done pulse.
  - abort has priority over run, wrSize and tx_ready in the same cycle.
  - In IDLE, abort has no effect.
- When undefined: the port is absent; only reset leaves a capture.

Test Plan:
- Basic capture: delay_cnt=4, read_cnt=8; arm; 10 valid samples 0x0..0x9, with run on sample 0x5 -> samples 0x0..0x9 written at addr 0..9 (0x5 counts as a pre-trigger write); readout tx_data 0x9,0x8,...,0x2 with done after the 8th handshake.
- Zero counts: delay_cnt=0, run on first cycle in SAMPLE -> no post-trigger write, RD_REQ next cycle. Separately, read_cnt=0 -> no mem_rd, done pulses once, busy falls.
- Backpressure: tx_ready low 5 cycles in RD_TX -> tx_valid/tx_data stable throughout, no mem_rd issued until handshake.
- Pointer wrap: AW=3, 12 samples written -> wr_ptr=4; read_cnt=6 reads addr 3,2,1,0,7,6.
- Ignored inputs: wrSize during DELAY leaves counts unchanged; arm during read ignored; run in IDLE ignored.
- Reset and abort: rst_n low in RD_TX -> tx_valid=0, busy=0, no done. With CAPTURE_CTRL_ABORT_EN, abort in DELAY -> IDLE next cycle, done stays 0.

Source files
------------

// File: rtl/capture_ctrl.sv
// Capture controller: records samples into a circular RAM around a trigger, then reads them back newest-first.
// Optional abort input is enabled by defining CAPTURE_CTRL_ABORT_EN.
module capture_ctrl #(
    parameter int DW = 32,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrSize,
    input  logic [31:0]   config_data,
    input  logic          arm,
    input  logic          run,
    input  logic          sti_valid,
    input  logic [DW-1:0] sti_data,
    output logic          mem_wr,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
`ifdef CAPTURE_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done
);

    // state    | meaning
    // IDLE     | waiting for arm; size register writable
    // SAMPLE   | pre-trigger capture
    // DELAY    | post-trigger capture, counting valid samples
    // RD_REQ   | issue RAM read (held off while a write is still pending)
    // RD_WAIT  | RAM data returning, load into tx_data
    // RD_TX    | presenting sample to transmitter
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAMPLE  = 3'd1;
    localparam logic [2:0] S_DELAY   = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_RD_TX   = 3'd5;

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [2:0]    state;
    logic [15:0]   read_cnt;
    logic [15:0]   delay_cnt;
    logic [15:0]   cnt;
    logic [15:0]   cnt_inc;
    logic [15:0]   rd_left;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_nxt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_ptr;
    logic          wr_pend;
    logic          cap_en;
    logic          rd_setup;
    logic          abort_hit;

`ifdef CAPTURE_CTRL_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // With delay_cnt=0 nothing is written after the trigger.
    assign cap_en = sti_valid && !abort_hit &&
                    ((state == S_SAMPLE) || ((state == S_DELAY) && (delay_cnt != 16'd0)));

    assign wr_ptr_nxt = cap_en ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign cnt_inc    = cnt + 16'd1;

    assign rd_setup = !abort_hit && (state == S_DELAY) &&
                      ((delay_cnt == 16'd0) || (sti_valid && (cnt_inc == delay_cnt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            mem_wdata <= '0;
            wr_ptr    <= '0;
        end else begin
            wr_pend <= cap_en;
            if (cap_en) begin
                wr_addr   <= wr_ptr;
                mem_wdata <= sti_data;
                wr_ptr    <= wr_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            read_cnt  <= '0;
            delay_cnt <= '0;
            cnt       <= '0;
            rd_left   <= '0;
            rd_ptr    <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                state    <= S_IDLE;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (wrSize) begin
                            read_cnt  <= config_data[15:0];
                            delay_cnt <= config_data[31:16];
                        end
                        if (arm) state <= S_SAMPLE;
                    end
                    S_SAMPLE: begin
                        if (run) begin
                            state <= S_DELAY;
                            cnt   <= '0;
                        end
                    end
                    S_DELAY: begin
                        if (rd_setup) begin
                            // newest sample sits one below the post-write pointer
                            rd_ptr  <= wr_ptr_nxt - PTR_ONE;
                            rd_left <= read_cnt;
                            if (read_cnt == 16'd0) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_RD_REQ;
                            end
                        end else if (cap_en) begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_RD_REQ: begin
                        if (!wr_pend) state <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        tx_data  <= mem_rdata;
                        tx_valid <= 1'b1;
                        state    <= S_RD_TX;
                    end
                    S_RD_TX: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            rd_ptr   <= rd_ptr - PTR_ONE;
                            rd_left  <= rd_left - 16'd1;
                            if (rd_left == 16'd1) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_RD_REQ;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // A write still in flight owns the RAM port; the read waits one cycle behind it.
    assign mem_wr   = wr_pend;
    assign mem_rd   = (state == S_RD_REQ) && !wr_pend && !abort_hit;
    assign mem_addr = mem_rd ? rd_ptr : wr_addr;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a behavioural sample RAM and write/read/transmit logs.
module tb_capture_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wrSize = 1'b0;
    logic [31:0]   config_data = '0;
    logic          arm = 1'b0;
    logic          run = 1'b0;
    logic          sti_valid = 1'b0;
    logic [DW-1:0] sti_data = '0;
    logic          mem_wr;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;
`ifdef CAPTURE_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif

    always #5 clk = ~clk;

    capture_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wrSize(wrSize), .config_data(config_data),
        .arm(arm), .run(run), .sti_valid(sti_valid), .sti_data(sti_data),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
`ifdef CAPTURE_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] ra_q[$];
    logic [31:0] tx_q[$];
    int done_n = 0;
    int both_n = 0;

    always @(negedge clk) begin
        if (mem_wr) begin
            wa_q.push_back(32'(mem_addr));
            wd_q.push_back(mem_wdata);
        end
        if (mem_rd) ra_q.push_back(32'(mem_addr));
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (done) done_n++;
        if (mem_wr && mem_rd) both_n++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        tx_q.delete();
        done_n = 0;
    endtask

    task automatic set_size(input logic [15:0] dly, input logic [15:0] rc);
        config_data = {dly, rc};
        wrSize = 1'b1;
        step();
        wrSize = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic sample(input logic [31:0] d, input logic r);
        sti_valid = 1'b1;
        sti_data  = d;
        run       = r;
        step();
        sti_valid = 1'b0;
        run       = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) step();
        chk(tag, 32'(busy), 32'd0);
        step();
    endtask

    task automatic wait_txv(input string tag);
        for (int i = 0; i < 100 && !tx_valid; i++) step();
        chk(tag, 32'(tx_valid), 32'd1);
    endtask

    initial begin
        // reset values
        step();
        step();
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        rst_n = 1'b1;
        step();
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);

        // basic capture: 10 samples, trigger on 0x5, delay 4, read 8
        clr();
        tx_ready = 1'b1;
        set_size(16'd4, 16'd8);
        do_arm();
        chk("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 10; i++) sample(32'(i), i == 5);
        wait_idle("t1_timeout");
        chk("t1_nwr", 32'(wa_q.size()), 10);
        for (int i = 0; i < 10 && i < wa_q.size(); i++) begin
            chk($sformatf("t1_waddr%0d", i), wa_q[i], 32'(i));
            chk($sformatf("t1_wdata%0d", i), wd_q[i], 32'(i));
        end
        chk("t1_nrd", 32'(ra_q.size()), 8);
        chk("t1_ntx", 32'(tx_q.size()), 8);
        for (int i = 0; i < 8 && i < ra_q.size() && i < tx_q.size(); i++) begin
            chk($sformatf("t1_raddr%0d", i), ra_q[i], 32'(9 - i));
            chk($sformatf("t1_tx%0d", i), tx_q[i], 32'(9 - i));
        end
        chk("t1_done", 32'(done_n), 1);

        // delay_cnt=0: only the trigger-cycle sample is written, read starts right after DELAY
        clr();
        set_size(16'd0, 16'd3);
        do_arm();
        sample(32'hA0, 1'b1);
        sti_valid = 1'b1;
        sti_data  = 32'hA1;
        step();
        sti_valid = 1'b0;
        chk("t2_rdreq", 32'(mem_rd), 1);
        chk("t2_rdaddr", 32'(mem_addr), 10);
        wait_idle("t2_timeout");
        chk("t2_nwr", 32'(wa_q.size()), 1);
        if (wa_q.size() > 0) chk("t2_wdata", wd_q[0], 32'hA0);
        chk("t2_ntx", 32'(tx_q.size()), 3);
        if (tx_q.size() == 3) begin
            chk("t2_tx0", tx_q[0], 32'hA0);
            chk("t2_tx1", tx_q[1], 32'h9);
            chk("t2_tx2", tx_q[2], 32'h8);
        end
        chk("t2_done", 32'(done_n), 1);

        // read_cnt=0: capture completes with a done pulse and no reads
        clr();
        set_size(16'd2, 16'd0);
        do_arm();
        sample(32'hB0, 1'b1);
        sample(32'hB1, 1'b0);
        sample(32'hB2, 1'b0);
        wait_idle("t2b_timeout");
        chk("t2b_nwr", 32'(wa_q.size()), 3);
        if (wa_q.size() == 3) chk("t2b_waddr2", wa_q[2], 13);
        chk("t2b_nrd", 32'(ra_q.size()), 0);
        chk("t2b_done", 32'(done_n), 1);

        // backpressure, with write pointer wrapping 15 -> 0
        clr();
        tx_ready = 1'b0;
        set_size(16'd1, 16'd2);
        do_arm();
        sample(32'hC0, 1'b1);
        sample(32'hC1, 1'b0);
        wait_txv("t3_txv_timeout");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_hold_valid%0d", k), 32'(tx_valid), 1);
            chk($sformatf("t3_hold_data%0d", k), tx_data, 32'hC1);
            chk($sformatf("t3_hold_rd%0d", k), 32'(mem_rd), 0);
            step();
        end
        chk("t3_nrd_stall", 32'(ra_q.size()), 1);
        tx_ready = 1'b1;
        wait_idle("t3_timeout");
        chk("t3_nrd", 32'(ra_q.size()), 2);
        if (ra_q.size() == 2) begin
            chk("t3_raddr0", ra_q[0], 15);
            chk("t3_raddr1", ra_q[1], 14);
        end
        chk("t3_ntx", 32'(tx_q.size()), 2);
        if (tx_q.size() == 2) chk("t3_tx1", tx_q[1], 32'hC0);

        // wrap readout; wrSize in DELAY and arm during readout are ignored
        clr();
        set_size(16'd3, 16'd6);
        do_arm();
        for (int i = 0; i < 20; i++) begin
            sti_valid = 1'b1;
            sti_data  = 32'(32'hD00 + i);
            run       = (i == 16);
            wrSize    = (i == 17);
            if (i == 17) config_data = {16'd1, 16'd1};
            step();
        end
        sti_valid = 1'b0;
        run = 1'b0;
        wrSize = 1'b0;
        wait_txv("t4_txv_timeout");
        arm = 1'b1;
        step();
        arm = 1'b0;
        wait_idle("t4_timeout");
        chk("t4_nwr", 32'(wa_q.size()), 20);
        chk("t4_nrd", 32'(ra_q.size()), 6);
        chk("t4_ntx", 32'(tx_q.size()), 6);
        if (ra_q.size() == 6 && tx_q.size() == 6) begin
            chk("t4_raddr3", ra_q[3], 0);
            chk("t4_raddr4", ra_q[4], 15);
            chk("t4_raddr5", ra_q[5], 14);
            chk("t4_tx0", tx_q[0], 32'hD13);
            chk("t4_tx4", tx_q[4], 32'hD0F);
        end
        chk("t4_done", 32'(done_n), 1);
        run = 1'b1;
        sti_valid = 1'b1;
        step();
        step();
        run = 1'b0;
        sti_valid = 1'b0;
        step();
        chk("t4_run_idle_busy", 32'(busy), 0);
        chk("t4_run_idle_nwr", 32'(wa_q.size()), 20);

        // async reset while presenting a sample
        clr();
        tx_ready = 1'b0;
        set_size(16'd0, 16'd2);
        do_arm();
        sample(32'hE0, 1'b1);
        wait_txv("t5_txv_timeout");
        rst_n = 1'b0;
        #1;
        chk("t5_tx_valid", 32'(tx_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_tx_data", tx_data, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t5_done", 32'(done_n), 0);
        chk("t5_busy_after", 32'(busy), 0);

`ifdef CAPTURE_CTRL_ABORT_EN
        clr();
        tx_ready = 1'b1;
        set_size(16'd5, 16'd2);
        do_arm();
        sample(32'hF0, 1'b1);
        sample(32'hF1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_tx_valid", 32'(tx_valid), 0);
        step();
        step();
        chk("t6_done", 32'(done_n), 0);
        chk("t6_nwr", 32'(wa_q.size()), 2);
`endif

        chk("wr_rd_overlap", 32'(both_n), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
